// File: rtl/hub75_scan.sv
// hub75_scan: scan generator for a 64x64 HUB75 panel (1/32 scan, two data
// halves). Each row is shifted out column by column while a painter supplies
// colour bits, then blanked, latched and displayed for OE_CYCLES cycles.
//
// Ports:
//   clk         system clock, all state changes on its rising edge
//   reset       asynchronous, active-high reset
//   frame       frame counter to painter (mod 8192)
//   subframe    subframe counter to painter (mod NUM_SUBFRAMES)
//   x, y        pixel address presented to the painter
//   rgb         painter colour {blu,grn,red} for the current x/y
//   panel_clk   HUB75 shift clock
//   panel_lat   HUB75 latch strobe (active high)
//   panel_oe_n  HUB75 output enable (active low)
//   panel_addr  HUB75 row-pair address
//   panel_rgb0  upper-half data {B,G,R}
//   panel_rgb1  lower-half data {B,G,R}
module hub75_scan #(
  parameter int OE_CYCLES     = 32,
  parameter int NUM_SUBFRAMES = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic [12:0] frame,
  output logic [7:0]  subframe,
  output logic [5:0]  x,
  output logic [5:0]  y,
  input  logic [2:0]  rgb,
  output logic        panel_clk,
  output logic        panel_lat,
  output logic        panel_oe_n,
  output logic [4:0]  panel_addr,
  output logic [2:0]  panel_rgb0,
  output logic [2:0]  panel_rgb1
);

  typedef enum logic [1:0] {SHIFT, BLANK, LATCH, DISPLAY} state_t;

  localparam logic [7:0] OE_LAST = 8'(OE_CYCLES - 1);
  localparam logic [7:0] SF_LAST = 8'(NUM_SUBFRAMES - 1);

  state_t      state_q, state_d;
  logic [1:0]  phase_q, phase_d;
  logic [5:0]  x_q, x_d;
  logic [5:0]  y_q, y_d;
  logic [4:0]  row_q, row_d;
  logic [7:0]  oe_cnt_q, oe_cnt_d;
  logic [12:0] frame_q, frame_d;
  logic [7:0]  subframe_q, subframe_d;
  logic        panel_clk_q, panel_clk_d;
  logic        panel_lat_q, panel_lat_d;
  logic        panel_oe_n_q, panel_oe_n_d;
  logic [4:0]  panel_addr_q, panel_addr_d;
  logic [2:0]  panel_rgb0_q, panel_rgb0_d;
  logic [2:0]  panel_rgb1_q, panel_rgb1_d;

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    x_d          = x_q;
    row_d        = row_q;
    oe_cnt_d     = oe_cnt_q;
    frame_d      = frame_q;
    subframe_d   = subframe_q;
    panel_addr_d = panel_addr_q;
    panel_rgb0_d = panel_rgb0_q;
    panel_rgb1_d = panel_rgb1_q;
    panel_clk_d  = 1'b0;

    unique case (state_q)
      SHIFT: begin
        phase_d = phase_q + 2'd1;
        unique case (phase_q)
          2'd0: panel_rgb0_d = rgb;
          2'd1: panel_rgb1_d = rgb;
          2'd2: panel_clk_d  = 1'b1;
          2'd3: begin
            x_d = x_q + 6'd1;
            if (x_q == 6'd63) state_d = BLANK;
          end
        endcase
      end
      BLANK: begin
        panel_addr_d = row_q;
        state_d      = LATCH;
      end
      LATCH: begin
        oe_cnt_d = 8'd0;
        state_d  = DISPLAY;
      end
      DISPLAY: begin
        oe_cnt_d = oe_cnt_q + 8'd1;
        if (oe_cnt_q == OE_LAST) begin
          oe_cnt_d = 8'd0;
          state_d  = SHIFT;
          row_d    = row_q + 5'd1;
          // Frame/subframe only move here so the painter sees them
          // constant across a whole row shift.
          if (row_q == 5'd31) begin
            if (subframe_q == SF_LAST) begin
              subframe_d = 8'd0;
              frame_d    = frame_q + 13'd1;
            end else begin
              subframe_d = subframe_q + 8'd1;
            end
          end
        end
      end
    endcase

    // Outputs are registered, so they are derived from the next state:
    // the flops then show the values belonging to the state being entered.
    panel_lat_d  = (state_d == LATCH);
    panel_oe_n_d = (state_d != DISPLAY);
    y_d          = {!((state_d == SHIFT) && (phase_d == 2'd0)), row_d};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= SHIFT;
      phase_q      <= 2'd0;
      x_q          <= 6'd0;
      y_q          <= 6'd0;
      row_q        <= 5'd0;
      oe_cnt_q     <= 8'd0;
      frame_q      <= 13'd0;
      subframe_q   <= 8'd0;
      panel_clk_q  <= 1'b0;
      panel_lat_q  <= 1'b0;
      panel_oe_n_q <= 1'b1;
      panel_addr_q <= 5'd0;
      panel_rgb0_q <= 3'd0;
      panel_rgb1_q <= 3'd0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      x_q          <= x_d;
      y_q          <= y_d;
      row_q        <= row_d;
      oe_cnt_q     <= oe_cnt_d;
      frame_q      <= frame_d;
      subframe_q   <= subframe_d;
      panel_clk_q  <= panel_clk_d;
      panel_lat_q  <= panel_lat_d;
      panel_oe_n_q <= panel_oe_n_d;
      panel_addr_q <= panel_addr_d;
      panel_rgb0_q <= panel_rgb0_d;
      panel_rgb1_q <= panel_rgb1_d;
    end
  end

  assign frame      = frame_q;
  assign subframe   = subframe_q;
  assign x          = x_q;
  assign y          = y_q;
  assign panel_clk  = panel_clk_q;
  assign panel_lat  = panel_lat_q;
  assign panel_oe_n = panel_oe_n_q;
  assign panel_addr = panel_addr_q;
  assign panel_rgb0 = panel_rgb0_q;
  assign panel_rgb1 = panel_rgb1_q;

endmodule

// File: tb/tb_hub75_scan.sv
// Bench for hub75_scan: three instances (default / NUM_SUBFRAMES=2,OE_CYCLES=1
// / NUM_SUBFRAMES=1) checked every cycle against a timeline model derived from
// the cycle count since reset release, plus hand-computed pin values.
module tb_hub75_scan;
  localparam int N = 3;

  logic        clk;
  logic        rst_w   [N];
  logic [12:0] frame_w [N];
  logic [7:0]  sf_w    [N];
  logic [5:0]  x_w     [N];
  logic [5:0]  y_w     [N];
  logic [2:0]  rgb_w   [N];
  logic        pclk_w  [N];
  logic        plat_w  [N];
  logic        oe_w    [N];
  logic [4:0]  addr_w  [N];
  logic [2:0]  rgb0_w  [N];
  logic [2:0]  rgb1_w  [N];

  int tcnt   [N];
  int fr_off [N];
  int prev_oe   [N];
  int prev_addr [N];
  int clk_hi, lat_hi, oe_lo;
  int nvec, nbad;

  // Painters: instance 0 uses {y[5],x[0],y[0]}, the others a constant colour.
  assign rgb_w[0] = {y_w[0][5], x_w[0][0], y_w[0][0]};
  assign rgb_w[1] = 3'b101;
  assign rgb_w[2] = 3'b101;

  hub75_scan #(.OE_CYCLES(32), .NUM_SUBFRAMES(16)) dut0 (
    .clk(clk), .reset(rst_w[0]), .frame(frame_w[0]), .subframe(sf_w[0]),
    .x(x_w[0]), .y(y_w[0]), .rgb(rgb_w[0]), .panel_clk(pclk_w[0]),
    .panel_lat(plat_w[0]), .panel_oe_n(oe_w[0]), .panel_addr(addr_w[0]),
    .panel_rgb0(rgb0_w[0]), .panel_rgb1(rgb1_w[0]));

  hub75_scan #(.OE_CYCLES(1), .NUM_SUBFRAMES(2)) dut1 (
    .clk(clk), .reset(rst_w[1]), .frame(frame_w[1]), .subframe(sf_w[1]),
    .x(x_w[1]), .y(y_w[1]), .rgb(rgb_w[1]), .panel_clk(pclk_w[1]),
    .panel_lat(plat_w[1]), .panel_oe_n(oe_w[1]), .panel_addr(addr_w[1]),
    .panel_rgb0(rgb0_w[1]), .panel_rgb1(rgb1_w[1]));

  hub75_scan #(.OE_CYCLES(32), .NUM_SUBFRAMES(1)) dut2 (
    .clk(clk), .reset(rst_w[2]), .frame(frame_w[2]), .subframe(sf_w[2]),
    .x(x_w[2]), .y(y_w[2]), .rgb(rgb_w[2]), .panel_clk(pclk_w[2]),
    .panel_lat(plat_w[2]), .panel_oe_n(oe_w[2]), .panel_addr(addr_w[2]),
    .panel_rgb0(rgb0_w[2]), .panel_rgb1(rgb1_w[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int oe_of(input int i);
    return (i == 1) ? 1 : 32;
  endfunction

  function automatic int ns_of(input int i);
    return (i == 0) ? 16 : ((i == 1) ? 2 : 1);
  endfunction

  function automatic int paint(input int i, input int col, input int yy);
    logic [2:0] c;
    if (i == 0) c = {yy[5], col[0], yy[0]};
    else        c = 3'b101;
    return int'(c);
  endfunction

  task automatic chk(input string nm, input int i, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nbad++;
      $display("FAIL %s inst%0d t=%0d got=%0d expected=%0d", nm, i, tcnt[i], act, exp);
    end
  endtask

  // Cycle index since reset release: 0 is the first cycle after release.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (rst_w[i]) tcnt[i] = 0;
      else          tcnt[i] = tcnt[i] + 1;
    end
  end

  task automatic check_inst(input int i);
    int t, len, rc, off, row, col, ph, e_addr;
    bit sh;
    if (rst_w[i]) begin
      chk("rst_frame", i, frame_w[i], 0);
      chk("rst_subframe", i, sf_w[i], 0);
      chk("rst_x", i, x_w[i], 0);
      chk("rst_y", i, y_w[i], 0);
      chk("rst_pclk", i, pclk_w[i], 0);
      chk("rst_lat", i, plat_w[i], 0);
      chk("rst_oe_n", i, oe_w[i], 1);
      chk("rst_addr", i, addr_w[i], 0);
      chk("rst_rgb0", i, rgb0_w[i], 0);
      chk("rst_rgb1", i, rgb1_w[i], 0);
      prev_oe[i] = 1;
      prev_addr[i] = 0;
      return;
    end
    t   = tcnt[i];
    len = 258 + oe_of(i);
    rc  = t / len;
    off = t % len;
    row = rc % 32;
    sh  = (off < 256);
    col = off / 4;
    ph  = off % 4;
    e_addr = (off >= 257) ? row : ((rc > 0) ? (rc - 1) % 32 : 0);

    chk("frame", i, frame_w[i], (fr_off[i] + rc / 32 / ns_of(i)) % 8192);
    chk("subframe", i, sf_w[i], (rc / 32) % ns_of(i));
    chk("x", i, x_w[i], sh ? col : 0);
    chk("pclk", i, pclk_w[i], (sh && ph == 3) ? 1 : 0);
    chk("lat", i, plat_w[i], (off == 257) ? 1 : 0);
    chk("oe_n", i, oe_w[i], (off >= 258) ? 0 : 1);
    chk("addr", i, addr_w[i], e_addr);
    if (sh) begin
      chk("y", i, y_w[i], (ph == 0) ? row : 32 + row);
      if (ph >= 2) begin
        chk("rgb0", i, rgb0_w[i], paint(i, col, row));
        chk("rgb1", i, rgb1_w[i], paint(i, col, 32 + row));
      end
    end
    // Protocol rules
    chk("lat_during_oe", i, int'(plat_w[i] && !oe_w[i]), 0);
    chk("addr_move_during_oe", i,
        int'(!oe_w[i] && prev_oe[i] == 0 && int'(addr_w[i]) != prev_addr[i]), 0);
    prev_oe[i] = oe_w[i];
    prev_addr[i] = addr_w[i];

    // Hand-computed pins
    if (i == 0) begin
      case (t)
        2:    chk("pin_no_rise_yet", i, pclk_w[i], 0);
        3:    chk("pin_first_rise", i, pclk_w[i], 1);
        7:    begin chk("pin_r0k1_rgb0", i, rgb0_w[i], 3'b010);
                    chk("pin_r0k1_rgb1", i, rgb1_w[i], 3'b110); end
        257:  begin chk("pin_lat", i, plat_w[i], 1); chk("pin_lat_addr", i, addr_w[i], 0); end
        258:  chk("pin_oe_start", i, oe_w[i], 0);
        289:  chk("pin_oe_last", i, oe_w[i], 0);
        290:  begin chk("pin_row1_oe", i, oe_w[i], 1); chk("pin_row1_y", i, y_w[i], 1); end
        293:  begin chk("pin_r1k0_rgb0", i, rgb0_w[i], 3'b001);
                    chk("pin_r1k0_rgb1", i, rgb1_w[i], 3'b101); end
        9247: chk("pin_addr31", i, addr_w[i], 31);
        9279: chk("pin_sf_before", i, sf_w[i], 0);
        9280: begin chk("pin_sf_after", i, sf_w[i], 1); chk("pin_frame0", i, frame_w[i], 0); end
        default: ;
      endcase
    end else if (i == 1) begin
      case (t)
        16575: chk("pin_f_before", i, frame_w[i], 0);
        16576: chk("pin_f_after", i, frame_w[i], 1);
        33151: chk("pin_f_8191", i, frame_w[i], 8191);
        33152: chk("pin_f_wrap", i, frame_w[i], 0);
        default: ;
      endcase
    end else begin
      if (t < 290) begin
        clk_hi += int'(pclk_w[i]);
        lat_hi += int'(plat_w[i]);
        oe_lo  += int'(!oe_w[i]);
      end
      case (t)
        290: begin chk("pin_clk_pulses", i, clk_hi, 64);
                   chk("pin_lat_pulses", i, lat_hi, 1);
                   chk("pin_oe_cycles", i, oe_lo, 32); end
        9279: chk("pin_ns1_f_before", i, frame_w[i], 0);
        9280: begin chk("pin_ns1_f_after", i, frame_w[i], 1); chk("pin_ns1_sf", i, sf_w[i], 0); end
        default: ;
      endcase
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) check_inst(i);
  end

  task automatic wait_t(input int i, input int target);
    for (int n = 0; n < 40000 && tcnt[i] != target; n++) @(negedge clk);
    chk("reach_cycle", i, tcnt[i], target);
  endtask

  // Assert reset asynchronously a little after the falling edge at cycle
  // 'target', check the panel is shut off before any clock edge, then release.
  task automatic async_reset_at(input int target);
    wait_t(0, target);
    #2 rst_w[0] = 1'b1;
    #1;
    chk("async_oe_n", 0, oe_w[0], 1);
    chk("async_pclk", 0, pclk_w[0], 0);
    chk("async_lat", 0, plat_w[0], 0);
    @(negedge clk);
    @(negedge clk);
    #1 rst_w[0] = 1'b0;
  endtask

  initial begin
    nvec = 0;
    nbad = 0;
    clk_hi = 0;
    lat_hi = 0;
    oe_lo = 0;
    for (int i = 0; i < N; i++) begin
      rst_w[i] = 1'b1;
      tcnt[i] = 0;
      fr_off[i] = 0;
      prev_oe[i] = 1;
      prev_addr[i] = 0;
    end
    repeat (3) @(negedge clk);
    #1;
    for (int i = 0; i < N; i++) rst_w[i] = 1'b0;

    async_reset_at(9550);  // mid-DISPLAY of row 32
    async_reset_at(6);     // SHIFT p2 of column 1
    async_reset_at(7);     // SHIFT p3, panel_clk high

    // Jump instance 1 to frame 8191 and watch it wrap on the next increment.
    wait_t(1, 20000);
    #1;
    fr_off[1] = (8191 - ((tcnt[1] / 259) / 32) / 2 + 8192) % 8192;
    force dut1.frame_q = 13'd8191;
    repeat (3) @(posedge clk);
    #1 release dut1.frame_q;
    wait_t(1, 33160);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
